pll_lock_sequencer: RTL

- Controls the PLL under test (CLKI/RST/CLKOP/CLKOS/LOCK): drives the PLL RST pin, waits for LOCK, qualifies lock stability, and retries a bounded number of times.
- Asserts a clean "ready" to downstream checkers (frequency/phase-shift tasks) only after a stable lock, and drops it on lock loss.
- Sits between sys_signals (Sysclk, reset) and the PLL instance. Runs entirely on Sysclk; LOCK is treated as asynchronous.

---
 rtl/pll_lock_sequencer_if.sv | 24 ++
 rtl/pll_lock_sequencer.sv | 118 +++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its environment.
// The master drives start and the PLL LOCK. The slave (the sequencer) returns status.
interface pll_lock_sequencer_if #(
   parameter int unsigned RETRY_W = 4
);
   logic               start;
   logic               lock_in;
   logic               pll_rst;
   logic               ready;
   logic               fail;
   logic [2:0]         state;
   logic [RETRY_W-1:0] retry_cnt;
   logic [7:0]         loss_cnt;

   modport master (
      output start, lock_in,
      input  pll_rst, ready, fail, state, retry_cnt, loss_cnt
   );

   modport slave (
      input  start, lock_in,
      output pll_rst, ready, fail, state, retry_cnt, loss_cnt
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock-qualification sequencer with bounded retries.
// It drives the PLL RST pin and asserts ready only after LOCK has stayed stable.
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_TIMEOUT  = 1024,
   parameter int unsigned STABLE_CYCLES = 64,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned RETRY_W       = 4
) (
   input logic                 Sysclk,
   input logic                 async_rst,
   pll_lock_sequencer_if.slave bus
);
   localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_C   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int unsigned TIMER_W = $clog2(MAX_C);

   typedef enum logic [2:0] {
      ST_ASSERT = 3'b001,
      ST_WAIT   = 3'b010,
      ST_STABLE = 3'b011,
      ST_LOCKED = 3'b100,
      ST_FAIL   = 3'b101
   } state_t;

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0]   retry_cnt_q, retry_cnt_d;
   logic [7:0]           loss_cnt_q, loss_cnt_d;
   logic                 lock_meta_q, lock_meta_d;
   logic                 lock_s_q, lock_s_d;
   logic                 pll_rst_q, pll_rst_d;
   logic                 ready_q, ready_d;
   logic                 fail_q, fail_d;
   logic                 fail_path;
   logic [RETRY_W-1:0]   retry_inc;

   always_comb begin
      lock_meta_d = bus.lock_in;
      lock_s_d    = lock_meta_q;
      state_d     = state_q;
      retry_cnt_d = retry_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      fail_path   = 1'b0;
      retry_inc   = retry_cnt_q + RETRY_W'(1);

      if (bus.start) begin
         state_d     = ST_ASSERT;
         retry_cnt_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT: if (timer_q == TIMER_W'(RST_CYCLES - 1)) state_d = ST_WAIT;
            // A lock seen on the timeout cycle takes precedence over the timeout.
            ST_WAIT: begin
               if (lock_s_q)                                     state_d   = ST_STABLE;
               else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1))   fail_path = 1'b1;
            end
            ST_STABLE: begin
               if (!lock_s_q) begin
                  fail_path = 1'b1;
               end else if (timer_q == TIMER_W'(STABLE_CYCLES - 1)) begin
                  state_d     = ST_LOCKED;
                  retry_cnt_d = '0;
               end
            end
            ST_LOCKED: begin
               if (!lock_s_q) begin
                  state_d = ST_ASSERT;
                  if (loss_cnt_q != 8'hFF) loss_cnt_d = loss_cnt_q + 8'd1;
               end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_ASSERT;
         endcase
      end

      if (fail_path) begin
         retry_cnt_d = retry_inc;
         state_d     = (retry_inc == RETRY_W'(MAX_RETRY)) ? ST_FAIL : ST_ASSERT;
      end

      timer_d   = (bus.start || (state_d != state_q)) ? '0 : timer_q + TIMER_W'(1);
      pll_rst_d = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
      ready_d   = (state_d == ST_LOCKED);
      fail_d    = (state_d == ST_FAIL);
   end

   always_ff @(posedge Sysclk or negedge async_rst) begin
      if (!async_rst) begin
         state_q     <= ST_ASSERT;
         timer_q     <= '0;
         retry_cnt_q <= '0;
         loss_cnt_q  <= '0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         pll_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_cnt_q <= retry_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         pll_rst_q   <= pll_rst_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fail      = fail_q;
   assign bus.state     = state_q;
   assign bus.retry_cnt = retry_cnt_q;
   assign bus.loss_cnt  = loss_cnt_q;
endmodule
